// File: rtl/pe_crossbar_nxn_reg_if.sv
// Handshake and configuration bundle for the registered NxN PE crossbar.
interface pe_crossbar_nxn_reg_if #(
    parameter int NUM_PORTS = 4,
    parameter int DATA_W    = 32
);
    localparam int SEL_W = $clog2(NUM_PORTS);

    logic [NUM_PORTS-1:0]        in_valid;
    logic [NUM_PORTS-1:0]        in_ready;
    logic [NUM_PORTS*DATA_W-1:0] in_data;
    logic [NUM_PORTS-1:0]        out_valid;
    logic [NUM_PORTS-1:0]        out_ready;
    logic [NUM_PORTS*DATA_W-1:0] out_data;
    logic                        cfg_wr;
    logic [NUM_PORTS*SEL_W-1:0]  cfg_sel;
    logic [NUM_PORTS-1:0]        cfg_en;
    logic                        cfg_busy;

    // Crossbar side
    modport slave (
        input  in_valid, in_data, out_ready, cfg_wr, cfg_sel, cfg_en,
        output in_ready, out_valid, out_data, cfg_busy
    );

    // Driver side (PE datapath / neighbour links / config master)
    modport master (
        output in_valid, in_data, out_ready, cfg_wr, cfg_sel, cfg_en,
        input  in_ready, out_valid, out_data, cfg_busy
    );
endinterface

// File: rtl/pe_crossbar_nxn_reg.sv
// Registered NxN PE routing crossbar. Each output picks its source input,
// one input may fork to several outputs (all-or-none), and route changes are
// applied only after every output register has drained.
module pe_crossbar_nxn_reg #(
    parameter int NUM_PORTS = 4,
    parameter int DATA_W    = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    pe_crossbar_nxn_reg_if.slave  bus
);
    localparam int SEL_W = $clog2(NUM_PORTS);

    typedef enum logic {RUN, DRAIN} state_t;

    state_t                       state, state_nxt;
    logic                         apply;
    logic [NUM_PORTS*SEL_W-1:0]   act_sel, pend_sel;
    logic [NUM_PORTS-1:0]         act_en, pend_en;
    logic [NUM_PORTS-1:0]         out_valid_r;
    logic [NUM_PORTS*DATA_W-1:0]  out_data_r;

    logic [NUM_PORTS-1:0][NUM_PORTS-1:0] route;   // route[i][j]: input i feeds output j
    logic [NUM_PORTS-1:0]         acc;
    logic [NUM_PORTS-1:0]         rdy;
    logic [NUM_PORTS-1:0]         fire;
    logic [NUM_PORTS-1:0]         load;
    logic [DATA_W-1:0]            ld_data [NUM_PORTS];

    // Route matrix from the active config; out-of-range selects match no input
    always_comb begin
        route = '0;
        for (int j = 0; j < NUM_PORTS; j++) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                route[i][j] = act_en[j] && (int'(act_sel[j*SEL_W +: SEL_W]) == i);
            end
        end
    end

    // Input readiness: every routed output must accept; unrouted inputs sink
    always_comb begin
        acc = ~out_valid_r | bus.out_ready;
        rdy = {NUM_PORTS{state == RUN}};
        for (int i = 0; i < NUM_PORTS; i++) begin
            for (int j = 0; j < NUM_PORTS; j++) begin
                if (route[i][j] && !acc[j]) rdy[i] = 1'b0;
            end
        end
        fire = bus.in_valid & rdy;
    end

    // Per-output load strobe and the data word selected for it
    always_comb begin
        load = '0;
        for (int j = 0; j < NUM_PORTS; j++) begin
            ld_data[j] = '0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (route[i][j]) begin
                    ld_data[j] = bus.in_data[i*DATA_W +: DATA_W];
                    if (fire[i]) load[j] = 1'b1;
                end
            end
        end
    end

    // Output registers: load on fork, otherwise drain when taken
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= '0;
            out_data_r  <= '0;
        end else begin
            for (int j = 0; j < NUM_PORTS; j++) begin
                if (load[j]) begin
                    out_valid_r[j]                   <= 1'b1;
                    out_data_r[j*DATA_W +: DATA_W]   <= ld_data[j];
                end else if (bus.out_ready[j]) begin
                    out_valid_r[j] <= 1'b0;
                end
            end
        end
    end

    // Next state: enter DRAIN on a config write, leave once empty with no new write
    always_comb begin
        state_nxt = state;
        apply     = 1'b0;
        unique case (state)
            RUN: begin
                if (bus.cfg_wr) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (!bus.cfg_wr && (out_valid_r == '0)) begin
                    state_nxt = RUN;
                    apply     = 1'b1;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= RUN;
        else     state <= state_nxt;
    end

    // Pending config captures every write; active config swaps atomically on exit
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_sel <= '0;
            pend_en  <= '0;
            act_en   <= '1;
            for (int j = 0; j < NUM_PORTS; j++) begin
                act_sel[j*SEL_W +: SEL_W] <= SEL_W'(j);
            end
        end else begin
            if (bus.cfg_wr) begin
                pend_sel <= bus.cfg_sel;
                pend_en  <= bus.cfg_en;
            end
            if (apply) begin
                act_sel <= pend_sel;
                act_en  <= pend_en;
            end
        end
    end

    assign bus.in_ready  = rdy;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.cfg_busy  = (state == DRAIN);

endmodule

// File: tb/tb_pe_crossbar_nxn_reg.sv
// Directed bench for the registered 4x4 PE crossbar with a per-output
// expected-word scoreboard drained by an independent monitor.
module tb_pe_crossbar_nxn_reg;
    localparam int N  = 4;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    logic [DW-1:0] q [N][$];

    pe_crossbar_nxn_reg_if #(.NUM_PORTS(N), .DATA_W(DW)) bus ();

    pe_crossbar_nxn_reg #(.NUM_PORTS(N), .DATA_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted output word must match the next expected word
    always @(negedge clk) begin
        if (!rst) begin
            for (int j = 0; j < N; j++) begin
                if (bus.out_valid[j] && bus.out_ready[j]) begin
                    if (q[j].size() == 0) begin
                        check($sformatf("unexpected_out%0d", j), {32'h0, bus.out_data[j*DW +: DW]}, 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        check($sformatf("out%0d_word", j), {32'h0, bus.out_data[j*DW +: DW]}, {32'h0, q[j].pop_front()});
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        for (int k = 0; k < 50 && bus.cfg_busy; k++) tick();
        check(name, {63'h0, bus.cfg_busy}, 64'h0);
    endtask

    task automatic set_cfg(input logic [7:0] sel, input logic [3:0] en, input string name);
        bus.cfg_sel = sel;
        bus.cfg_en  = en;
        bus.cfg_wr  = 1'b1;
        tick();
        bus.cfg_wr  = 1'b0;
        check({name, "_busy"}, {63'h0, bus.cfg_busy}, 64'h1);
        check({name, "_in_ready"}, {60'h0, bus.in_ready}, 64'h0);
        wait_idle({name, "_done"});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.in_valid  = '0;
        bus.in_data   = '0;
        bus.out_ready = '0;
        bus.cfg_wr    = 1'b0;
        bus.cfg_sel   = '0;
        bus.cfg_en    = '0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_out_valid", {60'h0, bus.out_valid}, 64'h0);
        check("rst_out_data", {bus.out_data[63:0]}, 64'h0);
        check("rst_busy", {63'h0, bus.cfg_busy}, 64'h0);
        check("rst_in_ready", {60'h0, bus.in_ready}, 64'hF);

        // 1: identity streaming, one word per cycle on every port
        bus.out_ready = 4'hF;
        for (int k = 0; k < 4; k++) begin
            bus.in_valid = 4'hF;
            for (int i = 0; i < N; i++) begin
                bus.in_data[i*DW +: DW] = 32'hA0 + i + 16 * k;
                q[i].push_back(32'hA0 + i + 16 * k);
            end
            check("t1_in_ready", {60'h0, bus.in_ready}, 64'hF);
            tick();
            check("t1_out_valid", {60'h0, bus.out_valid}, 64'hF);
            if (k == 0) begin
                for (int j = 0; j < N; j++)
                    check("t1_first_data", {32'h0, bus.out_data[j*DW +: DW]}, 32'hA0 + j);
            end
        end
        bus.in_valid = '0;
        tick();
        check("t1_drained", {60'h0, bus.out_valid}, 64'h0);

        // 2: broadcast in0 to all outputs with out2 stalled
        set_cfg(8'h00, 4'hF, "t2_cfg");
        bus.out_ready = 4'b1011;
        bus.in_valid  = 4'b0001;
        bus.in_data[0 +: DW] = 32'hDEAD;
        check("t2_rdy_first", {63'h0, bus.in_ready[0]}, 64'h1);
        for (int j = 0; j < N; j++) q[j].push_back(32'hDEAD);
        tick();
        check("t2_fork_valid", {60'h0, bus.out_valid}, 64'hF);
        bus.in_data[0 +: DW] = 32'hBEEF;
        check("t2_rdy_blocked", {63'h0, bus.in_ready[0]}, 64'h0);
        tick();
        tick();
        check("t2_stall_valid", {60'h0, bus.out_valid}, 64'h4);
        check("t2_stall_rdy", {63'h0, bus.in_ready[0]}, 64'h0);
        check("t2_hold_data", {32'h0, bus.out_data[2*DW +: DW]}, 64'hDEAD);
        bus.out_ready = 4'hF;
        #1;
        check("t2_rdy_release", {63'h0, bus.in_ready[0]}, 64'h1);
        for (int j = 0; j < N; j++) q[j].push_back(32'hBEEF);
        tick();
        bus.in_valid = '0;
        check("t2_second_valid", {60'h0, bus.out_valid}, 64'hF);
        for (int j = 0; j < N; j++)
            check("t2_second_data", {32'h0, bus.out_data[j*DW +: DW]}, 64'hBEEF);
        tick();

        // 3: reconfig waits for a held word, then rotates routes
        set_cfg(8'hE4, 4'hF, "t3_ident");
        bus.out_ready = 4'b1101;
        bus.in_valid  = 4'b0010;
        bus.in_data[1*DW +: DW] = 32'h1234;
        q[1].push_back(32'h1234);
        tick();
        bus.in_valid = '0;
        check("t3_held", {60'h0, bus.out_valid}, 64'h2);
        bus.cfg_sel = 8'h39;
        bus.cfg_en  = 4'hF;
        bus.cfg_wr  = 1'b1;
        tick();
        bus.cfg_wr = 1'b0;
        check("t3_busy", {63'h0, bus.cfg_busy}, 64'h1);
        check("t3_in_ready", {60'h0, bus.in_ready}, 64'h0);
        tick();
        check("t3_busy_hold", {63'h0, bus.cfg_busy}, 64'h1);
        bus.out_ready = 4'hF;
        tick();
        check("t3_busy_after_deliver", {63'h0, bus.cfg_busy}, 64'h1);
        tick();
        check("t3_applied", {63'h0, bus.cfg_busy}, 64'h0);
        bus.in_valid = 4'b0100;
        bus.in_data[2*DW +: DW] = 32'h77;
        q[1].push_back(32'h77);
        tick();
        bus.in_valid = '0;
        check("t3_rot_valid", {60'h0, bus.out_valid}, 64'h2);
        check("t3_rot_data", {32'h0, bus.out_data[1*DW +: DW]}, 64'h77);
        tick();

        // 4: two writes during DRAIN, only the last one takes effect
        bus.cfg_sel = 8'h03;
        bus.cfg_en  = 4'b0001;
        bus.cfg_wr  = 1'b1;
        tick();
        bus.cfg_sel = 8'h40;
        bus.cfg_en  = 4'b1000;
        tick();
        bus.cfg_wr = 1'b0;
        check("t4_busy", {63'h0, bus.cfg_busy}, 64'h1);
        tick();
        check("t4_done", {63'h0, bus.cfg_busy}, 64'h0);
        bus.in_valid = 4'b1010;
        bus.in_data[1*DW +: DW] = 32'h111;
        bus.in_data[3*DW +: DW] = 32'h333;
        q[3].push_back(32'h111);
        check("t4_in_ready", {60'h0, bus.in_ready}, 64'hF);
        tick();
        bus.in_valid = '0;
        check("t4_valid", {60'h0, bus.out_valid}, 64'h8);
        check("t4_data", {32'h0, bus.out_data[3*DW +: DW]}, 64'h111);
        tick();

        // 5: unrouted input sinks its word
        set_cfg(8'h03, 4'b0001, "t5_cfg");
        bus.in_valid = 4'b0010;
        bus.in_data[1*DW +: DW] = 32'h55;
        check("t5_in_ready", {63'h0, bus.in_ready[1]}, 64'h1);
        tick();
        bus.in_valid = '0;
        check("t5_no_valid", {60'h0, bus.out_valid}, 64'h0);

        // 6: reset while draining drops the held word and restores identity
        bus.out_ready = 4'b1110;
        bus.in_valid  = 4'b1000;
        bus.in_data[3*DW +: DW] = 32'hAB;
        tick();
        bus.in_valid = '0;
        check("t6_held", {60'h0, bus.out_valid}, 64'h1);
        bus.cfg_sel = 8'h00;
        bus.cfg_en  = 4'hF;
        bus.cfg_wr  = 1'b1;
        tick();
        bus.cfg_wr = 1'b0;
        check("t6_busy", {63'h0, bus.cfg_busy}, 64'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_rst_valid", {60'h0, bus.out_valid}, 64'h0);
        check("t6_rst_busy", {63'h0, bus.cfg_busy}, 64'h0);
        check("t6_rst_in_ready", {60'h0, bus.in_ready}, 64'hF);
        bus.out_ready = 4'hF;
        bus.in_valid  = 4'hF;
        for (int i = 0; i < N; i++) begin
            bus.in_data[i*DW +: DW] = 32'hC0 + i;
            q[i].push_back(32'hC0 + i);
        end
        tick();
        bus.in_valid = '0;
        check("t6_ident_valid", {60'h0, bus.out_valid}, 64'hF);
        for (int j = 0; j < N; j++)
            check("t6_ident_data", {32'h0, bus.out_data[j*DW +: DW]}, 32'hC0 + j);
        tick();
        tick();

        for (int j = 0; j < N; j++)
            check($sformatf("q%0d_empty", j), 64'(q[j].size()), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
